// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a length-prefixed, XOR-checksummed stream
// and writes little-endian 32-bit words into the instruction memory write port.
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CHECK,
    LOADED,
    FAILED
  } state_t;

  state_t         state;
  logic [7:0]     len_lo;
  logic [15:0]    len;
  logic [15:0]    word_idx;
  logic [1:0]     byte_cnt;
  logic [23:0]    part;
  logic [7:0]     chk;
  logic [TW-1:0]  timer;

  logic        accept;
  logic        timed_out;
  logic [15:0] len_full;

  assign accept    = in_valid && in_ready;
  assign timed_out = (timer == TW'(TIMEOUT - 1));
  assign len_full  = {in_data, len_lo};

  // Accepted bytes take priority over the idle timer, so a byte arriving on the
  // last allowed idle cycle still counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= 32'h0;
      wr_data      <= 32'h0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      words_loaded <= 16'd0;
      len_lo       <= 8'h0;
      len          <= 16'd0;
      word_idx     <= 16'd0;
      byte_cnt     <= 2'd0;
      part         <= 24'h0;
      chk          <= 8'h0;
      timer        <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, LOADED, FAILED: begin
          if (start) begin
            state        <= LEN0;
            in_ready     <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'd0;
            words_loaded <= 16'd0;
            word_idx     <= 16'd0;
            byte_cnt     <= 2'd0;
            chk          <= 8'h0;
            timer        <= '0;
          end
        end
        default: begin
          if (accept) begin
            timer <= '0;
            case (state)
              LEN0: begin
                len_lo <= in_data;
                state  <= LEN1;
              end
              LEN1: begin
                if (len_full == 16'd0 || len_full > 16'(DEPTH)) begin
                  state    <= FAILED;
                  in_ready <= 1'b0;
                  error    <= 1'b1;
                  err_code <= 2'd1;
                end else begin
                  len   <= len_full;
                  state <= DATA;
                end
              end
              DATA: begin
                chk      <= chk ^ in_data;
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                  2'd0: part[7:0]   <= in_data;
                  2'd1: part[15:8]  <= in_data;
                  2'd2: part[23:16] <= in_data;
                  default: begin
                    wr_en        <= 1'b1;
                    wr_data      <= {in_data, part};
                    wr_addr      <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                    word_idx     <= word_idx + 16'd1;
                    words_loaded <= words_loaded + 16'd1;
                    if (word_idx == len - 16'd1) begin
                      state <= CHECK;
                    end
                  end
                endcase
              end
              CHECK: begin
                in_ready <= 1'b0;
                if (in_data == chk) begin
                  state     <= LOADED;
                  done      <= 1'b1;
                  core_hold <= 1'b0;
                end else begin
                  state    <= FAILED;
                  error    <= 1'b1;
                  err_code <= 2'd2;
                end
              end
              default: ;
            endcase
          end else if (timed_out) begin
            state    <= FAILED;
            in_ready <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd3;
            byte_cnt <= 2'd0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a scoreboard queue holds the expected
// memory writes, filled as the bench streams bytes and drained on every wr_en.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam int          TMO   = 20;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  int waits = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_exp;
  logic [31:0] prog  [$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_hold(core_hold), .done(done), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  // Every write strobe must match the next expected word, in order.
  always @(negedge clk) begin
    if (reset && wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL write_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({wr_addr, wr_data} !== mon_exp) begin
          bad++;
          $display("[TB] FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 4 * TMO) begin
      @(negedge clk);
      n++;
      waits++;
    end
    if (n >= 4 * TMO) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake_timeout: got in_ready=0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int nbytes);
    for (int k = 0; k < nbytes; k++) send_byte(w[8*k +: 8], 0);
  endtask

  task automatic run_load(input int gap_max, input bit random_gaps,
                          input logic [7:0] chk_flip, input int start_at);
    int n;
    int gap;
    logic [7:0] x;
    logic [31:0] w;
    n = prog.size();
    x = 8'h00;
    pulse_start();
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      exp_q.push_back({BASE + 32'(i * 4), w});
      for (int k = 0; k < 4; k++) begin
        x ^= w[8*k +: 8];
        gap = random_gaps ? int'($urandom_range(0, gap_max)) : gap_max;
        if (start_at == i * 4 + k) start = 1'b1;
        send_byte(w[8*k +: 8], gap);
        start = 1'b0;
      end
    end
    gap = random_gaps ? int'($urandom_range(0, gap_max)) : gap_max;
    send_byte(x ^ chk_flip, gap);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, wr_en, done, error, err_code} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b, required 000000", {in_ready, wr_en, done, error, err_code});
    end
    total++;
    if ({words_loaded, wr_addr, wr_data} !== 80'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got wl=%h addr=%h data=%h, required all 0", words_loaded, wr_addr, wr_data);
    end
    total++;
    if (core_hold !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_hold: got %b, required 1", core_hold);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_basic();
    prog = {32'h0050_0013, 32'h00A0_0093};
    waits = 0;
    run_load(0, 1'b0, 8'h00, -1);
    total++;
    if ({done, error, core_hold} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL basic_status: got done/err/hold=%b, required 100", {done, error, core_hold});
    end
    total++;
    if (words_loaded !== 16'd2) begin
      bad++;
      $display("[TB] FAIL basic_words: got %0d, required 2", words_loaded);
    end
    total++;
    if (waits !== 0) begin
      bad++;
      $display("[TB] FAIL back_to_back_bubbles: got %0d stalls, required 0", waits);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({wr_addr, wr_data} !== {32'h4, 32'h00A0_0093}) begin
      bad++;
      $display("[TB] FAIL basic_hold_last: got %h/%h, required 00000004/00a00093", wr_addr, wr_data);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL basic_pending: got %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_bad_length(input logic [15:0] len);
    pulse_start();
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    total++;
    if ({error, err_code, in_ready, core_hold} !== 5'b10101) begin
      bad++;
      $display("[TB] FAIL bad_len_%0d: got err/code/rdy/hold=%b, required 10101", len, {error, err_code, in_ready, core_hold});
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({words_loaded, error, in_ready} !== {16'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL bad_len_ignore_%0d: got wl=%0d err=%b rdy=%b, required 0/1/0", len, words_loaded, error, in_ready);
    end
  endtask

  task automatic test_bad_checksum();
    prog = {32'h0050_0013, 32'h00A0_0093};
    run_load(0, 1'b0, 8'h01, -1);
    total++;
    if ({error, err_code, core_hold, done} !== 5'b11010) begin
      bad++;
      $display("[TB] FAIL chk_status: got err/code/hold/done=%b, required 11010", {error, err_code, core_hold, done});
    end
    total++;
    if (words_loaded !== 16'd2 || exp_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL chk_words: got wl=%0d pending=%0d, required 2/0", words_loaded, exp_q.size());
    end
  endtask

  task automatic test_stall();
    prog = {$urandom, $urandom, $urandom};
    run_load(TMO - 1, 1'b0, 8'h00, -1);
    total++;
    if ({done, error, words_loaded} !== {1'b1, 1'b0, 16'd3}) begin
      bad++;
      $display("[TB] FAIL stall_ok: got done=%b err=%b wl=%0d, required 1/0/3", done, error, words_loaded);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w0;
    w0 = 32'hDEAD_BEEF;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({BASE, w0});
    send_word(w0, 4);
    send_word(32'h1234_5678, 2);
    repeat (TMO - 1) @(negedge clk);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_early: got error=%b after %0d idle cycles, required 0", error, TMO - 1);
    end
    @(negedge clk);
    total++;
    if ({error, err_code, in_ready, words_loaded} !== {1'b1, 2'd3, 1'b0, 16'd1}) begin
      bad++;
      $display("[TB] FAIL timeout: got err=%b code=%0d rdy=%b wl=%0d, required 1/3/0/1", error, err_code, in_ready, words_loaded);
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL timeout_pending: got %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_random_valid();
    prog = {32'h0050_0013, 32'h00A0_0093, 32'hCAFE_F00D};
    run_load(3, 1'b1, 8'h00, -1);
    total++;
    if ({done, words_loaded, exp_q.size()} !== {1'b1, 16'd3, 32'd0}) begin
      bad++;
      $display("[TB] FAIL random_valid: got done=%b wl=%0d pending=%0d, required 1/3/0", done, words_loaded, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({BASE, 32'h0403_0201});
    send_word(32'h0403_0201, 4);
    send_word(32'h0807_0605, 2);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({in_ready, wr_en, done, error, err_code, words_loaded, wr_addr, wr_data, core_hold}
        !== {86'h0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL async_reset: got rdy=%b wl=%0d addr=%h data=%h hold=%b, required 0/0/0/0/1",
               in_ready, words_loaded, wr_addr, wr_data, core_hold);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    prog = {32'h1111_2222, 32'h3333_4444};
    run_load(0, 1'b0, 8'h00, 5);
    total++;
    if ({done, words_loaded, exp_q.size()} !== {1'b1, 16'd2, 32'd0}) begin
      bad++;
      $display("[TB] FAIL restart: got done=%b wl=%0d pending=%0d, required 1/2/0", done, words_loaded, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_bad_length(16'd0);
    test_bad_length(16'(DEPTH + 1));
    test_bad_checksum();
    test_stall();
    test_timeout();
    test_random_valid();
    test_reset_mid_load();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
